// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the pipeline hazard/halt sequencer.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } seq_state_t;

  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned DRAIN_CNT_W      = 4;
  localparam int unsigned PERF_W           = 32;

  // A load in ID/EX whose destination feeds an IF/ID source; r0 never hazards.
  function automatic logic load_use(input logic       dren,
                                    input logic [4:0] ex_rt,
                                    input logic [4:0] id_rs,
                                    input logic [4:0] id_rt);
    return dren && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (en_i && ~&cnt_q)      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) cnt_q <= cnt_d;

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline stall/flush/halt sequencer for a 5-stage pipeline.
// Define PIPE_PERF_EN to add stall_cycles/flush_events performance counters.
module pipeline_sequencer
  import cpu_types_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dmem_req,
  input  logic        dhit,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic [4:0]  idex_rt,
  input  logic        idex_dREN,
  input  logic        branch_taken,
  input  logic        halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
`ifdef PIPE_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
`endif
  output logic        halted
);

  seq_state_t             state_q, state_d;
  logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
  logic                   freeze, lu;

  assign freeze = dmem_req & ~dhit;
  assign lu     = load_use(idex_dREN, idex_rt, ifid_rs, ifid_rt);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    if (state_q == HALTED || freeze) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
    end else if (state_q == DRAIN) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (cnt_q == '0) state_d = HALTED;
      else             cnt_d   = cnt_q - 1'b1;
    end else if (halt) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = DRAIN;
      cnt_d      = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
    end else if (state_q == LU_STALL) begin
      // The stall cycle lets the load reach MEM; the hazard is gone next cycle.
      state_d = RUN;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      state_d    = LU_STALL;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halted = (state_q == HALTED);

`ifdef PIPE_PERF_EN
  logic stall_inc, flush_inc;

  assign stall_inc = ~pc_en & (state_q != HALTED);
  assign flush_inc = (state_q == RUN || state_q == LU_STALL) & ~freeze & ~halt & branch_taken;

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk_i (CLK),
    .clr_i (~nRST),
    .en_i  (stall_inc),
    .cnt_o (stall_cycles)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk_i (CLK),
    .clr_i (~nRST),
    .en_i  (flush_inc),
    .cnt_o (flush_events)
  );
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed scenarios plus random traffic vs. a behavioural model.
// Define PIPE_PERF_EN to also exercise the performance counters.
module tb_pipeline_sequencer;

  localparam int DC = 3;

  logic       CLK = 1'b0;
  logic       nRST, ihit, dmem_req, dhit, idex_dREN, branch_taken, halt;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  pipeline_sequencer #(.DRAIN_CYCLES(DC)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt), .idex_dREN(idex_dREN),
    .branch_taken(branch_taken), .halt(halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
`ifdef PIPE_PERF_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: halted flag, remaining drain cycles, pending one-shot load-use stall.
  bit          m_known = 0;
  bit          m_halted, m_pend;
  int          m_drain;
  logic [31:0] m_stall, m_flush;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Output vector order: pc,ifid,idex,exmem,memwb enables, ifid_flush, idex_flush, halted.
  task automatic model_cycle(output logic [7:0] o);
    bit fr, lu, brf;
    fr  = dmem_req && !dhit;
    lu  = idex_dREN && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    brf = 0;
    if (m_halted)          o = 8'b00000_00_1;
    else if (fr)           o = 8'b00000_00_0;
    else if (m_drain > 0) begin
      o = 8'b01111_11_0;
      m_drain--;
      if (m_drain == 0) m_halted = 1;
    end else if (halt) begin
      o = 8'b01111_11_0; m_drain = DC; m_pend = 0;
    end else if (branch_taken) begin
      o = 8'b11111_11_0; m_pend = 0; brf = 1;
    end else if (m_pend) begin
      o = 8'b11111_00_0; m_pend = 0;
    end else if (lu) begin
      o = 8'b00111_01_0; m_pend = 1;
    end else if (!ihit)    o = 8'b01111_10_0;
    else                   o = 8'b11111_00_0;
    if (!o[7] && !m_halted_prev(o) && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (brf && m_flush != 32'hFFFF_FFFF) m_flush++;
    if (!nRST) begin
      m_known = 1; m_halted = 0; m_pend = 0; m_drain = 0; m_stall = 0; m_flush = 0;
    end
  endtask

  // Stalls are counted outside HALTED; the halted bit of this cycle's output says where we were.
  function automatic bit m_halted_prev(input logic [7:0] o);
    return o[0];
  endfunction

  task automatic cyc(input string nm, input bit lit, input logic [7:0] lit_o);
    logic [7:0] got, exp;
    #4;
    got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};
`ifdef PIPE_PERF_EN
    if (m_known) begin
      chk({nm, ".stall_cycles"}, stall_cycles, m_stall);
      chk({nm, ".flush_events"}, flush_events, m_flush);
    end
`endif
    if (m_known) begin
      model_cycle(exp);
      chk({nm, ".model"}, {24'd0, got}, {24'd0, exp});
    end else begin
      model_cycle(exp);
    end
    if (lit) chk({nm, ".literal"}, {24'd0, got}, {24'd0, lit_o});
    @(posedge CLK); #1;
  endtask

  task automatic set_in(input bit r, input bit ih, input bit dm, input bit dh, input bit dr,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] xrt,
                        input bit br, input bit hl);
    nRST = r; ihit = ih; dmem_req = dm; dhit = dh; idex_dREN = dr;
    ifid_rs = rs; ifid_rt = rt; idex_rt = xrt; branch_taken = br; halt = hl;
  endtask

  task automatic idle();
    set_in(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    @(posedge CLK); #1;
    cyc("reset_hold", 0, 8'h00);
    idle();
    cyc("reset_state", 1, 8'b11111_00_0);

    // Load-use stall: one bubble cycle, then the LU_STALL cycle, then normal RUN.
    set_in(1, 1, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 0);
    cyc("lu_stall", 1, 8'b00111_01_0);
    cyc("lu_release", 1, 8'b11111_00_0);
    idle();
    cyc("lu_after", 1, 8'b11111_00_0);

    // r0 destination never hazards.
    set_in(1, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
    cyc("lu_r0", 1, 8'b11111_00_0);

    // Branch beats load-use and stays in RUN (a repeated load-use still stalls).
    set_in(1, 1, 0, 0, 1, 5'd7, 5'd0, 5'd7, 1, 0);
    cyc("br_over_lu", 1, 8'b11111_11_0);
    set_in(1, 1, 0, 0, 1, 5'd0, 5'd7, 5'd7, 0, 0);
    cyc("br_stayed_run", 1, 8'b00111_01_0);
    idle();
    cyc("br_lu_release", 1, 8'b11111_00_0);

    // Freeze during LU_STALL holds everything, then the stall cycle completes.
    set_in(1, 1, 0, 0, 1, 5'd3, 5'd0, 5'd3, 0, 0);
    cyc("fz_enter", 1, 8'b00111_01_0);
    set_in(1, 1, 1, 0, 1, 5'd3, 5'd0, 5'd3, 0, 0);
    for (int i = 0; i < 4; i++) cyc("fz_hold", 1, 8'b00000_00_0);
    set_in(1, 1, 1, 1, 1, 5'd3, 5'd0, 5'd3, 0, 0);
    cyc("fz_complete", 1, 8'b11111_00_0);
    idle();
    cyc("fz_after", 1, 8'b11111_00_0);

    // Halt: entry cycle, DC drain cycles, then sticky HALTED until reset.
    set_in(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    cyc("halt_entry", 1, 8'b01111_11_0);
    idle();
    for (int i = 0; i < DC; i++) cyc("drain", 1, 8'b01111_11_0);
    cyc("halted", 1, 8'b00000_00_1);
    set_in(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1);
    cyc("halted_sticky", 1, 8'b00000_00_1);
    set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cyc("halted_in_reset", 1, 8'b00000_00_1);
    idle();
    cyc("after_reset", 1, 8'b11111_00_0);

    // Reset mid-drain returns straight to RUN.
    set_in(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    cyc("halt_entry2", 1, 8'b01111_11_0);
    set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cyc("drain_reset", 1, 8'b01111_11_0);
    idle();
    cyc("after_drain_reset", 1, 8'b11111_00_0);

`ifdef PIPE_PERF_EN
    set_in(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cyc("perf_reset", 0, 8'h00);
    set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    for (int i = 0; i < 10; i++) cyc("ihit_miss", 1, 8'b01111_10_0);
    #4 chk("stall_cycles_10", stall_cycles, 32'd10);
    @(posedge CLK); #1;
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.u_stall_cnt.cnt_q;
    m_stall = 32'hFFFF_FFFF;
    cyc("sat_stall", 1, 8'b01111_10_0);
    #4 chk("stall_saturated", stall_cycles, 32'hFFFF_FFFF);
    @(posedge CLK); #1;
    idle();
    cyc("sat_idle", 1, 8'b11111_00_0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      set_in(m_halted ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) != 0),
             $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, $urandom_range(0, 1),
             $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
      cyc("random", 0, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
